bitmap_scanout: RTL and testbench



---
 rtl/cc_video_pkg.sv | 29 ++
 rtl/scan_timing.sv | 76 +++++++
 rtl/bitmap_scanout.sv | 126 ++++++++++++
 tb/tb_bitmap_scanout.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cc_video_pkg.sv
// rtl/cc_video_pkg.sv - shared video timing defaults and 4 bpp bitmap packing helpers
package cc_video_pkg;

   localparam int DEF_H_TOTAL  = 320;
   localparam int DEF_H_VIS    = 256;
   localparam int DEF_HS_START = 272;
   localparam int DEF_HS_LEN   = 32;
   localparam int DEF_V_TOTAL  = 256;
   localparam int DEF_V_VIS    = 232;
   localparam int DEF_VS_START = 240;
   localparam int DEF_VS_LEN   = 4;

   localparam int BMP_ADDR_W   = 15;

   typedef struct packed {
      logic hblank;
      logic vblank;
      logic hsync_n;
      logic vsync_n;
   } scan_sig_t;

   localparam scan_sig_t SIG_IDLE = '{hblank: 1'b1, vblank: 1'b1, hsync_n: 1'b1, vsync_n: 1'b1};

   // x[0] = 0 selects the high nibble; the CPU write path packs bytes the same way
   function automatic logic [3:0] nib_sel(input logic [7:0] b, input logic x0);
      return x0 ? b[3:0] : b[7:4];
   endfunction

endpackage

// File: rtl/scan_timing.sv
// rtl/scan_timing.sv - raster counters, raw blank/sync and their 2-stage pixel alignment delay
module scan_timing
   import cc_video_pkg::*;
#(
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int H_VIS    = DEF_H_VIS,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_LEN   = DEF_HS_LEN,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int V_VIS    = DEF_V_VIS,
   parameter int VS_START = DEF_VS_START,
   parameter int VS_LEN   = DEF_VS_LEN
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_pix_i,
   output logic [8:0] hcnt_o,
   output logic [7:0] vcnt_o,
   output logic       line_wrap_o,
   output logic       frame_wrap_o,
   output logic       hblank_o,
   output logic       vblank_o,
   output logic       hsync_n_o,
   output logic       vsync_n_o
);

   logic [8:0] hcnt_q, hcnt_d;
   logic [7:0] vcnt_q, vcnt_d;
   logic       h_last, v_last;
   scan_sig_t  raw_sig;
   scan_sig_t  dly1_q, dly2_q;

   always_comb begin
      h_last = (hcnt_q == 9'(H_TOTAL - 1));
      v_last = (vcnt_q == 8'(V_TOTAL - 1));
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (ce_pix_i) begin
         hcnt_d = h_last ? 9'd0 : hcnt_q + 9'd1;
         if (h_last) begin
            vcnt_d = v_last ? 8'd0 : vcnt_q + 8'd1;
         end
      end
      raw_sig.hblank  = (hcnt_q >= 9'(H_VIS));
      raw_sig.vblank  = (vcnt_q >= 8'(V_VIS));
      raw_sig.hsync_n = !((hcnt_q >= 9'(HS_START)) && (hcnt_q < 9'(HS_START + HS_LEN)));
      raw_sig.vsync_n = !((vcnt_q >= 8'(VS_START)) && (vcnt_q < 8'(VS_START + VS_LEN)));
   end

   // Two ce_pix stages match the fetch -> shift -> pix latency of the pixel path
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt_q <= 9'd0;
         vcnt_q <= 8'd0;
         dly1_q <= SIG_IDLE;
         dly2_q <= SIG_IDLE;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         if (ce_pix_i) begin
            dly1_q <= raw_sig;
            dly2_q <= dly1_q;
         end
      end
   end

   assign hcnt_o       = hcnt_q;
   assign vcnt_o       = vcnt_q;
   assign line_wrap_o  = ce_pix_i && h_last;
   assign frame_wrap_o = ce_pix_i && h_last && v_last;
   assign hblank_o     = dly2_q.hblank;
   assign vblank_o     = dly2_q.vblank;
   assign hsync_n_o    = dly2_q.hsync_n;
   assign vsync_n_o    = dly2_q.vsync_n;

endmodule

// File: rtl/bitmap_scanout.sv
// rtl/bitmap_scanout.sv - display-side 4 bpp bitmap reader with scroll, flip and raster timing
module bitmap_scanout
   import cc_video_pkg::*;
#(
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int H_VIS    = DEF_H_VIS,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_LEN   = DEF_HS_LEN,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int V_VIS    = DEF_V_VIS,
   parameter int VS_START = DEF_VS_START,
   parameter int VS_LEN   = DEF_VS_LEN
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce_pix,
   input  logic [7:0]            BD,
   input  logic                  HSCRLn,
   input  logic                  VSCRLn,
   input  logic                  FLIP,
   output logic [BMP_ADDR_W-1:0] rd_addr,
   output logic                  rd_req,
   input  logic [7:0]            rd_data,
   output logic [3:0]            pix,
   output logic                  hblank,
   output logic                  vblank,
   output logic                  hsync_n,
   output logic                  vsync_n
);

   logic [8:0] hcnt;
   logic [7:0] vcnt;
   logic       line_wrap, frame_wrap;

   scan_timing #(
      .H_TOTAL(H_TOTAL), .H_VIS(H_VIS), .HS_START(HS_START), .HS_LEN(HS_LEN),
      .V_TOTAL(V_TOTAL), .V_VIS(V_VIS), .VS_START(VS_START), .VS_LEN(VS_LEN)
   ) u_timing (
      .clk          (clk),
      .reset        (reset),
      .ce_pix_i     (ce_pix),
      .hcnt_o       (hcnt),
      .vcnt_o       (vcnt),
      .line_wrap_o  (line_wrap),
      .frame_wrap_o (frame_wrap),
      .hblank_o     (hblank),
      .vblank_o     (vblank),
      .hsync_n_o    (hsync_n),
      .vsync_n_o    (vsync_n)
   );

   logic [7:0]            hscroll_pend_q, hscroll_pend_d;
   logic [7:0]            vscroll_pend_q, vscroll_pend_d;
   logic [7:0]            hscroll_q, hscroll_d;
   logic [7:0]            vscroll_q, vscroll_d;
   logic                  flip_q, flip_d;
   logic [BMP_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic                  fetch_pend_q;
   logic [7:0]            fetch_reg_q, fetch_reg_d;
   logic [7:0]            shift_q, shift_d;
   logic [3:0]            pix_q, pix_d;
   logic [7:0]            sx, sy;
   logic                  fetch_now;

   always_comb begin
      // Horizontal scroll moves in pixel pairs so a fetch never straddles two bytes
      sx = hcnt[7:0] + {hscroll_q[7:1], 1'b0};
      sy = vcnt + vscroll_q;
      if (flip_q) begin
         sx = ~sx;
         sy = ~sy;
      end

      fetch_now = ce_pix && !reset && !hcnt[0] && (hcnt < 9'(H_VIS)) && (vcnt < 8'(V_VIS));
      rd_addr_d = fetch_now ? {sy, sx[7:1]} : rd_addr_q;

      hscroll_pend_d = HSCRLn ? hscroll_pend_q : BD;
      vscroll_pend_d = VSCRLn ? vscroll_pend_q : BD;
      hscroll_d      = line_wrap ? hscroll_pend_q : hscroll_q;
      vscroll_d      = frame_wrap ? vscroll_pend_q : vscroll_q;
      flip_d         = frame_wrap ? FLIP : flip_q;

      fetch_reg_d = fetch_pend_q ? rd_data : fetch_reg_q;
      shift_d     = shift_q;
      pix_d       = pix_q;
      if (ce_pix) begin
         if (hcnt[0]) begin
            shift_d = fetch_reg_q;
            pix_d   = nib_sel(fetch_reg_q, flip_q);
         end else begin
            pix_d   = nib_sel(shift_q, !flip_q);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hscroll_pend_q <= 8'd0;
         vscroll_pend_q <= 8'd0;
         hscroll_q      <= 8'd0;
         vscroll_q      <= 8'd0;
         flip_q         <= 1'b0;
         rd_addr_q      <= '0;
         fetch_pend_q   <= 1'b0;
         fetch_reg_q    <= 8'd0;
         shift_q        <= 8'd0;
         pix_q          <= 4'd0;
      end else begin
         hscroll_pend_q <= hscroll_pend_d;
         vscroll_pend_q <= vscroll_pend_d;
         hscroll_q      <= hscroll_d;
         vscroll_q      <= vscroll_d;
         flip_q         <= flip_d;
         rd_addr_q      <= rd_addr_d;
         fetch_pend_q   <= fetch_now;
         fetch_reg_q    <= fetch_reg_d;
         shift_q        <= shift_d;
         pix_q          <= pix_d;
      end
   end

   assign rd_req  = fetch_now;
   assign rd_addr = rd_addr_d;
   assign pix     = (hblank || vblank) ? 4'h0 : pix_q;

endmodule

// File: tb/tb_bitmap_scanout.sv
// tb/tb_bitmap_scanout.sv - directed bench with RAM model and pixel scoreboard for bitmap_scanout
module tb_bitmap_scanout;

   localparam int HT = 320, VT = 16, VV = 12, VSS = 13, VSL = 2;

   logic        clk = 1'b0, reset = 1'b1, ce_pix = 1'b0;
   logic        HSCRLn = 1'b1, VSCRLn = 1'b1, FLIP = 1'b0;
   logic [7:0]  BD = 8'd0, rd_data = 8'd0;
   logic [14:0] rd_addr;
   logic        rd_req;
   logic [3:0]  pix;
   logic        hblank, vblank, hsync_n, vsync_n;

   int   checks = 0, failures = 0, gap = 4, tb_h = 0, tb_v = 0;
   logic flip_act = 1'b0;
   logic [7:0] mem [0:32767];

   typedef struct { int h; int v; logic [3:0] nib; } pix_exp_t;
   pix_exp_t pixq[$];

   bitmap_scanout #(.V_TOTAL(VT), .V_VIS(VV), .VS_START(VSS), .VS_LEN(VSL)) dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix), .BD(BD), .HSCRLn(HSCRLn), .VSCRLn(VSCRLn),
      .FLIP(FLIP), .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data), .pix(pix),
      .hblank(hblank), .vblank(vblank), .hsync_n(hsync_n), .vsync_n(vsync_n)
   );

   initial forever #5 clk = ~clk;

   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk); #1;
         ce_pix = (cnt == 0);
         cnt = (cnt + 1) % gap;
      end
   end

   // Expected raster position (pre-edge hcnt/vcnt) and the frame's active flip
   initial forever begin
      @(posedge clk);
      if (reset) begin
         tb_h = 0; tb_v = 0; flip_act = 1'b0;
      end else if (ce_pix) begin
         if (tb_h == HT - 1) begin
            tb_h = 0;
            if (tb_v == VT - 1) begin tb_v = 0; flip_act = FLIP; end
            else tb_v++;
         end else tb_h++;
      end
   end

   // RAM: data valid for the clk after the request; expected pixels queued on each read
   initial begin
      logic [14:0] a;
      logic [7:0]  d;
      forever begin
         @(negedge clk); #2;
         if (rd_req === 1'b1) begin
            a = rd_addr;
            d = mem[a];
            pixq.push_back('{tb_h + 2, tb_v, flip_act ? d[3:0] : d[7:4]});
            pixq.push_back('{tb_h + 3, tb_v, flip_act ? d[7:4] : d[3:0]});
            @(posedge clk); #1 rd_data = d;
            @(posedge clk); #1 rd_data = ~d;
         end
      end
   end

   initial begin
      pix_exp_t e;
      forever begin
         @(negedge clk); #2;
         if (ce_pix === 1'b1 && !reset && pixq.size() > 0 && pixq[0].h == tb_h && pixq[0].v == tb_v) begin
            e = pixq.pop_front();
            chk($sformatf("pix_sb_%0d_%0d", e.h, e.v), 32'(pix), 32'(e.nib));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pos(input int h, input int v);
      int n;
      bit found;
      n = 0;
      found = 1'b0;
      while (!found && n < 60000) begin
         @(negedge clk); #2;
         n++;
         found = (ce_pix === 1'b1) && (tb_h == h) && (tb_v == v);
      end
      if (!found) chk($sformatf("wait_%0d_%0d", h, v), 32'(found), 32'd1);
   endtask

   task automatic fetch_chk(input string tag, input logic [14:0] addr);
      chk({tag, "_req"}, 32'(rd_req), 32'd1);
      chk({tag, "_addr"}, 32'(rd_addr), 32'(addr));
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_rd_req"}, 32'(rd_req), 32'd0);
      chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      chk({tag, "_pix"}, 32'(pix), 32'd0);
      chk({tag, "_hblank"}, 32'(hblank), 32'd1);
      chk({tag, "_vblank"}, 32'(vblank), 32'd1);
      chk({tag, "_hsync_n"}, 32'(hsync_n), 32'd1);
      chk({tag, "_vsync_n"}, 32'(vsync_n), 32'd1);
   endtask

   task automatic cpu_wr(input bit hs, input logic [7:0] val);
      @(negedge clk);
      BD = val;
      if (hs) HSCRLn = 1'b0; else VSCRLn = 1'b0;
      @(negedge clk);
      HSCRLn = 1'b1;
      VSCRLn = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hA5;
      mem[32767] = 8'hA5;

      repeat (5) @(posedge clk);
      @(negedge clk); #2;
      reset_chk("rst");
      @(negedge clk);
      reset = 1'b0;

      // Frame 0: first fetch, nibble order, hsync window, line wrap
      wait_pos(0, 0);   fetch_chk("first", 15'h0000);
      wait_pos(2, 0);   chk("pix_c0", 32'(pix), 32'hA); chk("hblank_vis", 32'(hblank), 32'd0);
      wait_pos(3, 0);   chk("pix_c1", 32'(pix), 32'h5);
      gap = 2;
      wait_pos(273, 0); chk("hsync_273", 32'(hsync_n), 32'd1);
      wait_pos(274, 0); chk("hsync_274", 32'(hsync_n), 32'd0);
      wait_pos(300, 0); chk("hblank_300", 32'(hblank), 32'd1); chk("pix_blank", 32'(pix), 32'd0);
      wait_pos(305, 0); chk("hsync_305", 32'(hsync_n), 32'd0);
      wait_pos(306, 0); chk("hsync_306", 32'(hsync_n), 32'd1);
      wait_pos(0, 1);   fetch_chk("line1", 15'h0080);

      // Vertical blank/sync and address hold during blanking
      wait_pos(100, 11); chk("vblank_11", 32'(vblank), 32'd0);
      wait_pos(100, 12); chk("vblank_12", 32'(vblank), 32'd1); chk("vsync_12", 32'(vsync_n), 32'd1);
      chk("noreq_vbl", 32'(rd_req), 32'd0); chk("addr_hold", 32'(rd_addr), 32'h05FF);
      wait_pos(100, 13); chk("vsync_13", 32'(vsync_n), 32'd0);
      wait_pos(100, 14); chk("vsync_14", 32'(vsync_n), 32'd0);
      cpu_wr(1'b0, 8'h05);
      cpu_wr(1'b1, 8'h11);
      wait_pos(100, 15); chk("vsync_15", 32'(vsync_n), 32'd1);

      // Frame 1: scroll applied, deferred write, write on the wrap clk
      wait_pos(0, 0);   fetch_chk("scroll", 15'h0288);
      wait_pos(100, 2); fetch_chk("pre_defer", 15'h03BA);
      cpu_wr(1'b1, 8'h40);
      wait_pos(102, 2); fetch_chk("defer_same", 15'h03BB);
      wait_pos(0, 3);   fetch_chk("defer_next0", 15'h0420);
      wait_pos(102, 3); fetch_chk("defer_next102", 15'h0453);
      wait_pos(319, 3);
      BD = 8'h80; HSCRLn = 1'b0;
      @(negedge clk); HSCRLn = 1'b1;
      wait_pos(0, 4);   fetch_chk("wrap_old", 15'h04A0);
      wait_pos(0, 5);   fetch_chk("wrap_new", 15'h0540);
      wait_pos(100, 14);
      @(negedge clk); BD = 8'h00; HSCRLn = 1'b0; VSCRLn = 1'b0; FLIP = 1'b1;
      @(negedge clk); HSCRLn = 1'b1; VSCRLn = 1'b1;

      // Frame 2: flip
      wait_pos(0, 0);   fetch_chk("flip", 15'h7FFF);
      wait_pos(2, 0);   chk("flip_pix_c0", 32'(pix), 32'h5);
      wait_pos(3, 0);   chk("flip_pix_c1", 32'(pix), 32'hA);
      wait_pos(100, 6); fetch_chk("flip_mid", 15'h7CCD);

      // Mid-frame reset
      #1 reset = 1'b1;
      #1 reset_chk("midrst");
      repeat (3) @(negedge clk);
      pixq.delete();
      FLIP = 1'b0;
      reset = 1'b0;
      wait_pos(0, 0);   fetch_chk("post_rst", 15'h0000);
      wait_pos(2, 0);   chk("post_rst_pix", 32'(pix), 32'hA);
      wait_pos(10, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
